// File: rtl/t01_seq_alu_if.sv
// Request/response bundle for t01_seq_alu: the issuer drives the master side, the ALU the slave side.
interface t01_seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       AluOP;
  logic [WIDTH-1:0] Data1;
  logic [WIDTH-1:0] Data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] AluResult;
  logic             Zero;
  logic             Negative;
  logic             Overflow;
  logic             DivZero;
  logic             Illegal;

  modport master (
    output in_valid, AluOP, Data1, Data2, out_ready,
    input  in_ready, out_valid, AluResult, Zero, Negative, Overflow, DivZero, Illegal
  );
  modport slave (
    input  in_valid, AluOP, Data1, Data2, out_ready,
    output in_ready, out_valid, AluResult, Zero, Negative, Overflow, DivZero, Illegal
  );
endinterface

// File: rtl/t01_seq_alu.sv
// Sequential RV32I/RV32M ALU: base ops in one cycle, mul/div iterate one bit per cycle.
// Define T01_ALU_MULDIV_EN to build the multiplier/divider; otherwise every M op reports Illegal.
module t01_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  t01_seq_alu_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  typedef struct packed {
    logic ovf;
    logic dz;
    logic ill;
  } flags_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  flags_t           flg_q, flg_d;

  logic [WIDTH-1:0] a, b, sum, dif, base_res;
  logic [SH_W-1:0]  shamt;
  logic             base_ovf, base_ill;

  assign a     = bus.Data1;
  assign b     = bus.Data2;
  assign sum   = a + b;
  assign dif   = a - b;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    base_res = '0;
    base_ovf = 1'b0;
    base_ill = 1'b0;
    case (bus.AluOP[3:0])
      4'b0000: begin
        base_res = sum;
        base_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b1000: begin
        base_res = dif;
        base_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: base_res = a << shamt;
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b0100: base_res = a ^ b;
      4'b0101: base_res = a >> shamt;
      4'b1101: base_res = $unsigned($signed(a) >>> shamt);
      4'b0110: base_res = a | b;
      4'b0111: base_res = a & b;
      4'b0011: base_res = b;
      default: base_ill = 1'b1;
    endcase
  end

`ifdef T01_ALU_MULDIV_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;

  logic [2:0]         f3;
  logic               s1, s2, div_z, div_ovf;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     madd, dsh;
  logic               dge;
  logic [WIDTH-1:0]   drem, quo, rem, fin;
  logic [2*WIDTH-1:0] step, prod;

  // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both, everything else unsigned.
  assign f3      = bus.AluOP[2:0];
  assign s1      = a[WIDTH-1] && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110);
  assign s2      = b[WIDTH-1] && (f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b110);
  assign mag_a   = s1 ? -a : a;
  assign mag_b   = s2 ? -b : b;
  assign div_z   = f3[2] && (b == '0);
  assign div_ovf = f3[2] && !f3[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);

  // acc = {hi, lo}: product accumulator for mul, {remainder, dividend/quotient} for div.
  assign madd = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign dsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign dge  = dsh >= {1'b0, dvs_q};
  assign drem = dge ? dsh[WIDTH-1:0] - dvs_q : dsh[WIDTH-1:0];
  assign step = f3_q[2] ? {drem, acc_q[WIDTH-2:0], dge} : {madd, acc_q[WIDTH-1:1]};
  assign prod = qneg_q ? -step : step;
  assign quo  = qneg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign rem  = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

  always_comb begin
    fin = '0;
    case (f3_q)
      3'b000:                 fin = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin = quo;
      default:                fin = rem;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flg_d   = flg_q;
`ifdef T01_ALU_MULDIV_EN
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = DONE;
          flg_d   = '0;
          if (!bus.AluOP[4]) begin
            res_d     = base_res;
            flg_d.ovf = base_ovf;
            flg_d.ill = base_ill;
          end
`ifdef T01_ALU_MULDIV_EN
          else if (div_z) begin
            res_d    = f3[1] ? a : '1;
            flg_d.dz = 1'b1;
          end else if (div_ovf) begin
            res_d     = f3[1] ? '0 : a;
            flg_d.ovf = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            f3_d    = f3;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            dvs_d   = mag_b;
            qneg_d  = s1 ^ s2;
            rneg_d  = s1;
          end
`else
          else begin
            res_d     = '0;
            flg_d.ill = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
`ifdef T01_ALU_MULDIV_EN
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        // Final iteration also forms the signed result so DONE follows immediately.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          res_d   = fin;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          res_d   = '0;
          flg_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      flg_q   <= '0;
`ifdef T01_ALU_MULDIV_EN
      cnt_q   <= '0;
      f3_q    <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
`ifdef T01_ALU_MULDIV_EN
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  // res_q and flags are cleared outside DONE, so the outputs read zero in IDLE/BUSY.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.AluResult = res_q;
  assign bus.Zero      = (state_q == DONE) && (res_q == '0);
  assign bus.Negative  = res_q[WIDTH-1];
  assign bus.Overflow  = flg_q.ovf;
  assign bus.DivZero   = flg_q.dz;
  assign bus.Illegal   = flg_q.ill;
endmodule
